// File: rtl/mipi_rx_rst_seq_if.sv
// mipi_rx_rst_seq_if: lock/restart inputs and reset/status outputs of the receive-path reset sequencer
// master (sequencer): in pll_lock_i, soft_rst_i; out pll_rst_o, pd_dphy_o, dom_rst_n_o, ready_o, fault_o, state_o, retry_cnt_o, loss_cnt_o
// slave (PHY/consumer side): the same signals with directions reversed
interface mipi_rx_rst_seq_if #(
   parameter int NUM_DOM = 3
);
   logic               pll_lock_i;
   logic               soft_rst_i;
   logic               pll_rst_o;
   logic               pd_dphy_o;
   logic [NUM_DOM-1:0] dom_rst_n_o;
   logic               ready_o;
   logic               fault_o;
   logic [2:0]         state_o;
   logic [3:0]         retry_cnt_o;
   logic [7:0]         loss_cnt_o;
   modport master (
      input  pll_lock_i, soft_rst_i,
      output pll_rst_o, pd_dphy_o, dom_rst_n_o, ready_o, fault_o, state_o, retry_cnt_o, loss_cnt_o
   );
   modport slave (
      output pll_lock_i, soft_rst_i,
      input  pll_rst_o, pd_dphy_o, dom_rst_n_o, ready_o, fault_o, state_o, retry_cnt_o, loss_cnt_o
   );
endinterface

// File: rtl/mipi_rx_rst_seq.sv
// mipi_rx_rst_seq: PLL reset, lock qualification, DPHY power-up and staggered domain reset release with retry/fault
// ref_clk_i  27 MHz reference clock
// reset_n_i  asynchronous active-low reset, deasserted through a 2-flop synchroniser
// bus        master modport: pll_lock_i (async), soft_rst_i (level) in; pll_rst_o, pd_dphy_o, dom_rst_n_o,
//            ready_o, fault_o, state_o, retry_cnt_o, loss_cnt_o out, all registered
module mipi_rx_rst_seq #(
   parameter int NUM_DOM          = 3,
   parameter int CNT_W            = 16,
   parameter int PLL_RST_CYC      = 16,
   parameter int LOCK_STABLE_CYC  = 256,
   parameter int LOCK_TIMEOUT_CYC = 4096,
   parameter int DPHY_PU_CYC      = 64,
   parameter int STAGGER_CYC      = 16,
   parameter int LOSS_FILT        = 4,
   parameter int MAX_RETRY        = 7
) (
   input logic               ref_clk_i,
   input logic               reset_n_i,
   mipi_rx_rst_seq_if.master bus
);
   typedef enum logic [2:0] {
      PLL_RST   = 3'd1,
      WAIT_LOCK = 3'd2,
      DPHY_PU   = 3'd3,
      RELEASE   = 3'd4,
      RUN       = 3'd5,
      FAULT     = 3'd6
   } state_t;
   if (NUM_DOM < 1 || NUM_DOM > 8 || MAX_RETRY < 0 || MAX_RETRY > 15 ||
       PLL_RST_CYC < 1 || LOCK_STABLE_CYC < 1 || DPHY_PU_CYC < 1 || STAGGER_CYC < 1 || LOSS_FILT < 1 ||
       LOCK_TIMEOUT_CYC <= LOCK_STABLE_CYC ||
       (PLL_RST_CYC >> CNT_W) != 0 || (LOCK_STABLE_CYC >> CNT_W) != 0 || (LOCK_TIMEOUT_CYC >> CNT_W) != 0 ||
       (DPHY_PU_CYC >> CNT_W) != 0 || (STAGGER_CYC >> CNT_W) != 0 || (LOSS_FILT >> CNT_W) != 0) begin : g_bad_param
      $error("mipi_rx_rst_seq: parameter out of range");
   end
   state_t             state;
   logic [1:0]         rst_ff;
   logic [1:0]         lock_ff;
   logic               rst_n;
   logic               lock_s;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   stab;
   logic [CNT_W-1:0]   lf;
   logic [CNT_W-1:0]   cnt_n;
   logic [CNT_W-1:0]   stab_n;
   logic [CNT_W-1:0]   lf_n;
   logic [NUM_DOM-1:0] dom;
   logic               pll_rst;
   logic               pd_dphy;
   logic               ready;
   logic               fault;
   logic [3:0]         retry;
   logic [7:0]         loss;
   logic               watch;
   logic               lost;
   always_ff @(posedge ref_clk_i or negedge reset_n_i)
      if (!reset_n_i) rst_ff <= '0;
      else rst_ff <= {rst_ff[0], 1'b1};
   assign rst_n = rst_ff[1];
   always_ff @(posedge ref_clk_i or negedge rst_n)
      if (!rst_n) lock_ff <= '0;
      else lock_ff <= {lock_ff[0], bus.pll_lock_i};
   assign lock_s = lock_ff[1];
   assign cnt_n  = cnt + 1'b1;
   assign stab_n = lock_s ? stab + 1'b1 : '0;
   assign lf_n   = lock_s ? '0 : lf + 1'b1;
   // lock loss is only meaningful once the PLL has been qualified
   assign watch  = state inside {DPHY_PU, RELEASE, RUN};
   assign lost   = watch && lf_n == CNT_W'(LOSS_FILT);
   always_ff @(posedge ref_clk_i or negedge rst_n)
      if (!rst_n) begin
         state   <= PLL_RST;
         cnt     <= '0;
         stab    <= '0;
         lf      <= '0;
         dom     <= '0;
         pll_rst <= 1'b1;
         pd_dphy <= 1'b1;
         ready   <= 1'b0;
         fault   <= 1'b0;
         retry   <= '0;
         loss    <= '0;
      end else if (bus.soft_rst_i) begin
         state   <= PLL_RST;
         cnt     <= '0;
         stab    <= '0;
         lf      <= '0;
         dom     <= '0;
         pll_rst <= 1'b1;
         pd_dphy <= 1'b1;
         ready   <= 1'b0;
         fault   <= 1'b0;
         retry   <= '0;
      end else if (lost) begin
         state   <= PLL_RST;
         cnt     <= '0;
         stab    <= '0;
         lf      <= '0;
         dom     <= '0;
         pll_rst <= 1'b1;
         pd_dphy <= 1'b1;
         ready   <= 1'b0;
         loss    <= loss + 8'(loss != 8'hff);
      end else begin
         lf <= watch ? lf_n : '0;
         case (state)
            PLL_RST:
               if (cnt_n == CNT_W'(PLL_RST_CYC)) begin
                  state   <= WAIT_LOCK;
                  pll_rst <= 1'b0;
                  cnt     <= '0;
                  stab    <= '0;
               end else cnt <= cnt_n;
            WAIT_LOCK: begin
               // cnt is the attempt timeout and keeps running across lock glitches
               stab <= stab_n;
               cnt  <= cnt_n;
               if (stab_n == CNT_W'(LOCK_STABLE_CYC)) begin
                  state   <= DPHY_PU;
                  pd_dphy <= 1'b0;
                  cnt     <= '0;
               end else if (cnt_n == CNT_W'(LOCK_TIMEOUT_CYC)) begin
                  cnt     <= '0;
                  stab    <= '0;
                  pll_rst <= 1'b1;
                  if (retry < 4'(MAX_RETRY)) begin
                     state <= PLL_RST;
                     retry <= retry + 4'd1;
                  end else begin
                     state <= FAULT;
                     fault <= 1'b1;
                  end
               end
            end
            DPHY_PU:
               if (cnt_n == CNT_W'(DPHY_PU_CYC)) begin
                  state <= RELEASE;
                  dom   <= NUM_DOM'(1);
                  cnt   <= '0;
               end else cnt <= cnt_n;
            RELEASE:
               // dom fills as a thermometer, so its top bit marks the last release
               if (dom[NUM_DOM-1]) begin
                  state <= RUN;
                  ready <= 1'b1;
                  retry <= '0;
               end else if (cnt_n == CNT_W'(STAGGER_CYC)) begin
                  dom <= NUM_DOM'({dom, 1'b1});
                  cnt <= '0;
               end else cnt <= cnt_n;
            default: ;
         endcase
      end
   assign bus.pll_rst_o   = pll_rst;
   assign bus.pd_dphy_o   = pd_dphy;
   assign bus.dom_rst_n_o = dom;
   assign bus.ready_o     = ready;
   assign bus.fault_o     = fault;
   assign bus.state_o     = state;
   assign bus.retry_cnt_o = retry;
   assign bus.loss_cnt_o  = loss;
endmodule

// File: tb/tb_mipi_rx_rst_seq.sv
// tb_mipi_rx_rst_seq: directed and randomized bring-up, retry, glitch, soft-restart and async-reset checks
module tb_mipi_rx_rst_seq;
   localparam int ND   = 3;
   localparam int PR   = 4;
   localparam int LS   = 8;
   localparam int LT   = 32;
   localparam int DP   = 5;
   localparam int ST   = 3;
   localparam int LF   = 2;
   localparam int MR   = 2;
   localparam int SYNC = 2;
   localparam logic [2:0] S_PLL = 3'd1, S_WAIT = 3'd2, S_DPHY = 3'd3, S_REL = 3'd4, S_RUN = 3'd5, S_FAULT = 3'd6;
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   t0;
   int   d;
   int   exp_t;
   int   exp_loss = 0;
   mipi_rx_rst_seq_if #(.NUM_DOM(ND)) bus ();
   mipi_rx_rst_seq #(
      .NUM_DOM(ND), .CNT_W(16), .PLL_RST_CYC(PR), .LOCK_STABLE_CYC(LS), .LOCK_TIMEOUT_CYC(LT),
      .DPHY_PU_CYC(DP), .STAGGER_CYC(ST), .LOSS_FILT(LF), .MAX_RETRY(MR)
   ) dut (
      .ref_clk_i(clk),
      .reset_n_i(reset_n),
      .bus(bus)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic tick(input int n);
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask
   task automatic wait_st(input logic [2:0] s, input bit eq, input int bound, input string tag);
      int n = 0;
      do begin
         tick(1);
         n++;
      end while (((bus.state_o == s) != eq) && n < bound);
      if ((bus.state_o == s) != eq) chk({tag, " wait bound"}, n, bound + 1);
   endtask
   initial begin
      bus.pll_lock_i = 1'b0;
      bus.soft_rst_i = 1'b0;
      tick(3);
      chk("rst state", bus.state_o, S_PLL);
      chk("rst pll_rst", bus.pll_rst_o, 1);
      chk("rst pd_dphy", bus.pd_dphy_o, 1);
      chk("rst dom", bus.dom_rst_n_o, 0);
      chk("rst ready", bus.ready_o, 0);
      chk("rst fault", bus.fault_o, 0);
      chk("rst retry", bus.retry_cnt_o, 0);
      chk("rst loss", bus.loss_cnt_o, 0);
      // nominal bring-up with a random lock delay
      reset_n = 1'b1;
      t0 = cyc;
      wait_st(S_WAIT, 1, 50, "release");
      chk("release to wait", cyc - t0, SYNC + PR);
      chk("pll_rst fall", bus.pll_rst_o, 0);
      d = $urandom_range(0, 10);
      tick(d);
      bus.pll_lock_i = 1'b1;
      t0 = cyc;
      wait_st(S_DPHY, 1, LT + 5, "lock");
      chk("lock to pd", cyc - t0, SYNC + LS);
      chk("pd fall", bus.pd_dphy_o, 0);
      t0 = cyc;
      wait_st(S_REL, 1, 20, "pu");
      chk("pu time", cyc - t0, DP);
      chk("dom first", bus.dom_rst_n_o, 1);
      for (int i = 1; i < ND; i++) begin
         tick(ST - 1);
         chk("dom hold", bus.dom_rst_n_o, (1 << i) - 1);
         tick(1);
         chk("dom step", bus.dom_rst_n_o, (1 << (i + 1)) - 1);
         chk("not ready yet", bus.ready_o, 0);
      end
      tick(1);
      chk("run state", bus.state_o, S_RUN);
      chk("run ready", bus.ready_o, 1);
      chk("run retry", bus.retry_cnt_o, 0);
      // one-cycle glitch ignored, two-cycle drop is a loss
      tick($urandom_range(1, 20));
      bus.pll_lock_i = 1'b0;
      tick(1);
      bus.pll_lock_i = 1'b1;
      tick(6);
      chk("glitch state", bus.state_o, S_RUN);
      chk("glitch ready", bus.ready_o, 1);
      chk("glitch loss", bus.loss_cnt_o, exp_loss);
      bus.pll_lock_i = 1'b0;
      tick(LF);
      bus.pll_lock_i = 1'b1;
      tick(1);
      chk("pre loss state", bus.state_o, S_RUN);
      tick(1);
      exp_loss++;
      chk("loss state", bus.state_o, S_PLL);
      chk("loss dom", bus.dom_rst_n_o, 0);
      chk("loss pd", bus.pd_dphy_o, 1);
      chk("loss pll_rst", bus.pll_rst_o, 1);
      chk("loss ready", bus.ready_o, 0);
      chk("loss cnt", bus.loss_cnt_o, exp_loss);
      chk("loss retry", bus.retry_cnt_o, 0);
      t0 = cyc;
      wait_st(S_WAIT, 1, 20, "reseq pll");
      chk("reseq pll len", cyc - t0, PR);
      t0 = cyc;
      wait_st(S_DPHY, 1, LT + 5, "reseq lock");
      chk("reseq lock len", cyc - t0, LS);
      t0 = cyc;
      wait_st(S_RUN, 1, 60, "reseq run");
      chk("reseq release len", cyc - t0, DP + (ND - 1) * ST + 1);
      // soft restart in the same cycle as a loss trigger wins
      bus.pll_lock_i = 1'b0;
      tick(LF + 1);
      chk("pre soft state", bus.state_o, S_RUN);
      bus.soft_rst_i = 1'b1;
      tick(1);
      chk("soft+loss state", bus.state_o, S_PLL);
      chk("soft+loss cnt", bus.loss_cnt_o, exp_loss);
      chk("soft+loss dom", bus.dom_rst_n_o, 0);
      bus.soft_rst_i = 1'b0;
      tick(3);
      chk("soft+loss later", bus.loss_cnt_o, exp_loss);
      // lock never comes: bounded retries then fault
      bus.soft_rst_i = 1'b1;
      tick(3);
      chk("soft hold state", bus.state_o, S_PLL);
      bus.soft_rst_i = 1'b0;
      for (int i = 0; i <= MR; i++) begin
         t0 = cyc;
         wait_st(S_WAIT, 1, 20, "retry pll");
         chk("retry pll len", cyc - t0, PR);
         chk("retry pll_rst low", bus.pll_rst_o, 0);
         t0 = cyc;
         wait_st(S_WAIT, 0, LT + 5, "retry window");
         chk("retry window", cyc - t0, LT);
         chk("retry pll_rst high", bus.pll_rst_o, 1);
         if (i < MR) begin
            chk("retry state", bus.state_o, S_PLL);
            chk("retry cnt", bus.retry_cnt_o, i + 1);
         end else begin
            chk("fault state", bus.state_o, S_FAULT);
            chk("fault flag", bus.fault_o, 1);
            chk("fault retry", bus.retry_cnt_o, MR);
            chk("fault pd", bus.pd_dphy_o, 1);
            chk("fault dom", bus.dom_rst_n_o, 0);
         end
      end
      bus.pll_lock_i = 1'b1;
      tick(2 * LS + SYNC);
      chk("fault sticky", bus.state_o, S_FAULT);
      bus.soft_rst_i = 1'b1;
      tick(1);
      chk("unfault state", bus.state_o, S_PLL);
      chk("unfault fault", bus.fault_o, 0);
      chk("unfault retry", bus.retry_cnt_o, 0);
      chk("unfault loss", bus.loss_cnt_o, exp_loss);
      bus.soft_rst_i = 1'b0;
      // lock 7 high / 1 low / high after a random lead: success or timeout from plain arithmetic
      for (int k = 0; k < 5; k++) begin
         d = (k == 0) ? 0 : (k == 1) ? 20 : $urandom_range(0, 20);
         bus.pll_lock_i = 1'b0;
         bus.soft_rst_i = 1'b1;
         tick(2);
         bus.soft_rst_i = 1'b0;
         wait_st(S_WAIT, 1, 20, "toggle pll");
         t0 = cyc;
         tick(d);
         bus.pll_lock_i = 1'b1;
         tick(LS - 1);
         bus.pll_lock_i = 1'b0;
         tick(1);
         bus.pll_lock_i = 1'b1;
         wait_st(S_WAIT, 0, LT + 5, "toggle leave");
         exp_t = d + SYNC + (LS - 1) + 1 + LS;
         if (exp_t <= LT) begin
            chk("toggle lock time", cyc - t0, exp_t);
            chk("toggle lock state", bus.state_o, S_DPHY);
            chk("toggle lock retry", bus.retry_cnt_o, 0);
         end else begin
            chk("toggle timeout time", cyc - t0, LT);
            chk("toggle timeout state", bus.state_o, S_PLL);
            chk("toggle timeout retry", bus.retry_cnt_o, 1);
         end
      end
      // async reset in the middle of the release stagger
      bus.soft_rst_i = 1'b1;
      tick(1);
      bus.soft_rst_i = 1'b0;
      wait_st(S_REL, 1, 100, "async rel");
      tick(ST);
      chk("async pre dom", bus.dom_rst_n_o, 3);
      #2 reset_n = 1'b0;
      #1;
      chk("async dom", bus.dom_rst_n_o, 0);
      chk("async pd", bus.pd_dphy_o, 1);
      chk("async pll_rst", bus.pll_rst_o, 1);
      chk("async state", bus.state_o, S_PLL);
      chk("async ready", bus.ready_o, 0);
      chk("async loss", bus.loss_cnt_o, 0);
      tick(2);
      reset_n = 1'b1;
      tick(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
